// File: rtl/instruction_fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    // Mask that clears the two low address bits, since fetches are word aligned.
    localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK = ~ADDR_W'(3);

endpackage

// File: rtl/pc_register.sv
// Program counter: holds, steps by one instruction word, or loads a redirect target.
module pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: a redirect wins over the sequential step; the add wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr & WORD_ALIGN_MASK;
        end else if (incr) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    // PC register with synchronous reset to the boot address.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word request at a time to instruction
// memory and hands each fetched word to the control unit with its address.
//
// state | meaning
// IDLE  | no request outstanding, waiting for fetch_en
// REQ   | request at imem_addr outstanding, data will be kept
// DRAIN | request at a stale address outstanding, data will be dropped
// HOLD  | instruction presented on instr, waiting for instr_ready
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic [ADDR_W-1:0]  instr_pc_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic               pc_incr;
    logic               req_active;

    // The PC follows pc_load in every state; the FSM only decides when to step it.
    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clock     (clock),
        .reset     (reset),
        .load      (pc_load),
        .load_addr (pc_target),
        .incr      (pc_incr),
        .pc        (pc),
        .pc_next   (pc_next)
    );

    assign req_active = (state_q == REQ) || (state_q == DRAIN);

    // Next-state, capture and request-address logic.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        addr_d     = addr_q;
        pc_incr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (pc_load) begin
                        state_d = fetch_en ? REQ : IDLE;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc;
                        pc_incr    = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (pc_load) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_d = fetch_en ? REQ : IDLE;
                end
            end
            HOLD: begin
                if (pc_load || instr_ready) begin
                    state_d = fetch_en ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The request address is frozen while a request is outstanding and is
        // reloaded from the upcoming PC whenever a fresh request starts.
        if ((state_d == REQ) && !(req_active && !imem_ack)) begin
            addr_d = pc_next;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign imem_req    = req_active;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == HOLD);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for the instruction fetch unit.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic        pc_load;
    logic [63:0] pc_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch #(
        .RESET_PC (64'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_en = 1'b0; pc_load = 1'b0; pc_target = '0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        step(); step();
        n_checks++;
        if (instr_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", instr_valid); else n_pass++;
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", imem_req); else n_pass++;
        n_checks++;
        if (imem_addr !== 64'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else n_pass++;
        n_checks++;
        if (instr !== 32'h0) $display("FAIL reset_instr got %h want 0", instr); else n_pass++;
        n_checks++;
        if (instr_pc !== 64'h0) $display("FAIL reset_instr_pc got %h want 0", instr_pc); else n_pass++;
    endtask

    task automatic test_first_fetch();
        reset = 1'b0; fetch_en = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0)
            $display("FAIL first_req got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr);
        else n_pass++;
        step(); step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0 || instr_valid !== 1'b0)
            $display("FAIL first_wait got req=%0b addr=%h valid=%0b want 1/0/0", imem_req, imem_addr, instr_valid);
        else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'h910193E4;
        step();
        imem_ack = 1'b0; imem_rdata = '0;
        n_checks++;
        if (instr !== 32'h910193E4 || instr_pc !== 64'h0 || instr_valid !== 1'b1)
            $display("FAIL first_data got instr=%h pc=%h valid=%0b want 910193e4/0/1", instr, instr_pc, instr_valid);
        else n_pass++;
    endtask

    task automatic test_hold_stall();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (instr !== 32'h910193E4 || instr_valid !== 1'b1 || imem_req !== 1'b0)
                $display("FAIL hold_stall got instr=%h valid=%0b req=%0b want 910193e4/1/0", instr, instr_valid, imem_req);
            else n_pass++;
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h4 || instr_valid !== 1'b0)
            $display("FAIL hold_release got req=%0b addr=%h valid=%0b want 1/4/0", imem_req, imem_addr, instr_valid);
        else n_pass++;
    endtask

    task automatic test_redirect_drain();
        pc_load = 1'b1; pc_target = 64'h103;
        step();
        pc_load = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h4)
            $display("FAIL drain_addr got req=%0b addr=%h want 1/4", imem_req, imem_addr);
        else n_pass++;
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h100 || instr_valid !== 1'b0 || instr !== 32'h910193E4)
            $display("FAIL drain_redirect got req=%0b addr=%h valid=%0b instr=%h want 1/100/0/910193e4",
                     imem_req, imem_addr, instr_valid, instr);
        else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'h11111111;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr !== 32'h11111111 || instr_pc !== 64'h100 || instr_valid !== 1'b1)
            $display("FAIL drain_next got instr=%h pc=%h valid=%0b want 11111111/100/1", instr, instr_pc, instr_valid);
        else n_pass++;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_checks++;
        if (imem_addr !== 64'h104) $display("FAIL drain_seq got addr=%h want 104", imem_addr); else n_pass++;
    endtask

    task automatic test_ack_with_load();
        imem_ack = 1'b1; imem_rdata = 32'h22222222; pc_load = 1'b1; pc_target = 64'h200;
        step();
        imem_ack = 1'b0; pc_load = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h200 || instr_valid !== 1'b0 || instr !== 32'h11111111)
            $display("FAIL ack_load got req=%0b addr=%h valid=%0b instr=%h want 1/200/0/11111111",
                     imem_req, imem_addr, instr_valid, instr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        pc_load = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h33333333;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL wrap_addr got %h want fffffffffffffffc", imem_addr);
        else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'h44444444;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC || instr !== 32'h44444444 || instr_valid !== 1'b1)
            $display("FAIL wrap_data got pc=%h instr=%h valid=%0b want fffffffffffffffc/44444444/1",
                     instr_pc, instr, instr_valid);
        else n_pass++;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_checks++;
        if (imem_addr !== 64'h0 || imem_req !== 1'b1)
            $display("FAIL wrap_next got addr=%h req=%0b want 0/1", imem_addr, imem_req);
        else n_pass++;
    endtask

    task automatic test_hold_redirect();
        imem_ack = 1'b1; imem_rdata = 32'h55555555;
        step();
        imem_ack = 1'b0;
        pc_load = 1'b1; pc_target = 64'h40;
        step();
        pc_load = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h40)
            $display("FAIL hold_redirect got valid=%0b req=%0b addr=%h want 0/1/40", instr_valid, imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_fetch_en_low();
        fetch_en = 1'b0;
        step(); step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h40)
            $display("FAIL en_low_outstanding got req=%0b addr=%h want 1/40", imem_req, imem_addr);
        else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'h66666666;
        step();
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL en_low_idle got req=%0b valid=%0b want 0/0", imem_req, instr_valid);
        else n_pass++;
        fetch_en = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h44)
            $display("FAIL en_resume got req=%0b addr=%h want 1/44", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        reset = 1'b1;
        step();
        reset = 1'b0; fetch_en = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h77777777;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0)
            $display("FAIL stray_ack got valid=%0b req=%0b instr=%h want 0/0/0", instr_valid, imem_req, instr);
        else n_pass++;
        fetch_en = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0)
            $display("FAIL reset_refetch got req=%0b addr=%h want 1/0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        instr_ready = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h88888888;
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== 32'h88888888)
            $display("FAIL b2b_first got valid=%0b pc=%h instr=%h want 1/0/88888888", instr_valid, instr_pc, instr);
        else n_pass++;
        imem_rdata = 32'h99999999;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h4)
            $display("FAIL b2b_req got req=%0b addr=%h want 1/4", imem_req, imem_addr);
        else n_pass++;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h4 || instr !== 32'h99999999)
            $display("FAIL b2b_second got valid=%0b pc=%h instr=%h want 1/4/99999999", instr_valid, instr_pc, instr);
        else n_pass++;
        instr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_drain();
        test_ack_with_load();
        test_wrap();
        test_hold_redirect();
        test_fetch_en_low();
        test_reset_mid_req();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
